// File: rtl/sms_power_engine_if.sv
// Operand/result handshake bundle for sms_power_engine; master drives operands and accepts results.
interface sms_power_engine_if #(
    parameter int N  = 6,
    parameter int EW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic [EW-1:0] e;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  y;
    logic          busy;

    modport master (
        output in_valid, x, e, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, x, e, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/sms_power_engine.sv
// GF(2^N) y = x^e ^ {N{t}} via MSB-first square-and-multiply; result valid EW+1 edges after accept.
// One operation in flight: in_ready only in IDLE, y held in DONE until out_ready.
module sms_power_engine #(
    parameter int           N        = 6,
    parameter logic [N:0]   POLY     = 7'b1000011,
    parameter int           EW       = 6,
    parameter logic [N-1:0] LIN_MASK = 6'b010100
) (
    input logic          clk,
    input logic          rst,
    sms_power_engine_if.slave bus
);
    localparam int CW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_x;
    logic [EW-1:0] r_e;
    logic          r_t;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_fin;
    logic [N-1:0]  r_y;

    logic [N-1:0]  w_sq;
    logic [N-1:0]  w_step;
    logic          w_t;

    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] p;
        logic [N-1:0] s;
        p = '0;
        s = a;
        for (int i = 0; i < N; i++) begin
            if (b[i]) p = p ^ s;
            s = s[N-1] ? ((s << 1) ^ POLY[N-1:0]) : (s << 1);
        end
        return p;
    endfunction

    assign w_t    = ^(bus.x & LIN_MASK);
    assign w_sq   = gf_mul(r_acc, r_acc);
    assign w_step = r_e[r_cnt] ? gf_mul(w_sq, r_x) : w_sq;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = RUN;
            RUN:     if (r_fin)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The final XOR is taken from the registered accumulator so the
    // output register is not fed by the end of the two-multiplier path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_e   <= '0;
            r_t   <= 1'b0;
            r_acc <= '0;
            r_cnt <= '0;
            r_fin <= 1'b0;
            r_y   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x   <= bus.x;
                        r_e   <= bus.e;
                        r_t   <= w_t;
                        r_acc <= N'(1);
                        r_cnt <= CW'(EW - 1);
                        r_fin <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_fin) begin
                        r_y <= r_acc ^ {N{r_t}};
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                        else             r_fin <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.y         = r_y;
endmodule

// File: tb/tb_sms_power_engine.sv
// Bench for sms_power_engine: directed known powers, reset/abort cases, then random operands vs a reference model.
module tb_sms_power_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sms_power_engine_if #(.N(6), .EW(6)) bus();

    sms_power_engine #(
        .N(6), .POLY(7'b1000011), .EW(6), .LIN_MASK(6'b010100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Carry-less product to 2N-1 bits, then long division by the polynomial.
    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        logic [10:0] poly;
        p    = '0;
        poly = 11'b00001000011;
        for (int i = 0; i < 6; i++)
            if (b[i]) p = p ^ (11'(a) << i);
        for (int k = 10; k >= 6; k--)
            if (p[k]) p = p ^ (poly << (k - 6));
        return p[5:0];
    endfunction

    function automatic logic [5:0] ref_y(input logic [5:0] xv, input logic [5:0] ev);
        logic [5:0] r;
        logic       t;
        r = 6'h01;
        for (int i = 0; i < int'(ev); i++) r = ref_mul(r, xv);
        t = ^(xv & 6'b010100);
        return r ^ {6{t}};
    endfunction

    task automatic do_op(input logic [5:0] xv, input logic [5:0] ev, input logic [5:0] exp_y,
                         input int hold, input string tag);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "/rdy"}, 32'(bus.in_ready), 32'd1);
        bus.x = xv;
        bus.e = ev;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            // Operands wander and in_valid toggles while the result is in flight.
            bus.x = 6'($urandom);
            bus.e = 6'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
            if (bus.out_valid) break;
        end
        chk({tag, "/lat"}, 32'(k), 32'd7);
        chk({tag, "/y"}, 32'(bus.y), 32'(exp_y));
        chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "/inrdy_done"}, 32'(bus.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.x = 6'($urandom);
            @(posedge clk); #1;
            chk({tag, "/hold_v"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "/hold_y"}, 32'(bus.y), 32'(exp_y));
            chk({tag, "/hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "/ret_v"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "/ret_rdy"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "/ret_busy"}, 32'(bus.busy), 32'd0);
        if (k >= 20) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        logic       seen_v;
        logic [5:0] rx;
        logic [5:0] re;

        // Reset held with in_valid and out_ready high: reset must win.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.x = 6'h3F;
        bus.e = 6'h3F;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst/busy", 32'(bus.busy), 32'd0);
        chk("rst/y", 32'(bus.y), 32'd0);
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;

        do_op(6'h02, 6'd6,  6'h03, 5, "a2e6");
        do_op(6'h02, 6'd13, 6'h0A, 0, "a2e13");
        do_op(6'h02, 6'd62, 6'h21, 1, "a2inv");
        do_op(6'h04, 6'd63, 6'h3E, 0, "x4e63");
        do_op(6'h00, 6'd0,  6'h01, 0, "zero_e0");
        do_op(6'h00, 6'd5,  6'h00, 2, "zero_e5");
        do_op(6'h14, 6'd0,  6'h01, 0, "x14e0");

        // Abort three cycles into RUN.
        bus.x = 6'h02;
        bus.e = 6'd63;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort/in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort/out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort/y", 32'(bus.y), 32'd0);
        chk("abort/busy", 32'(bus.busy), 32'd0);
        seen_v = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen_v = seen_v | bus.out_valid;
        end
        chk("abort/no_result", 32'(seen_v), 32'd0);
        do_op(6'h02, 6'd6, 6'h03, 0, "post_abort");

        for (int i = 0; i < 40; i++) begin
            rx = 6'($urandom);
            re = 6'($urandom);
            do_op(rx, re, ref_y(rx, re), $urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
